// File: rtl/gpio_conditioner.sv
// Per-channel GPIO pad conditioning: tri-state drive with loopback sampling,
// multi-flop synchronizer, glitch-rejecting debounce, and edge pulses.
module gpio_conditioner #(
    parameter int GPIO_WIDTH      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    inout  wire  [GPIO_WIDTH-1:0] gpio,
    input  logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] gpio_output,
    input  logic [GPIO_WIDTH-1:0] debounce_bypass,
    output logic [GPIO_WIDTH-1:0] gpio_input,
    output logic [GPIO_WIDTH-1:0] gpio_rise,
    output logic [GPIO_WIDTH-1:0] gpio_fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0] raw;
    logic [GPIO_WIDTH-1:0] synced;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] level_q, level_d;
    logic [GPIO_WIDTH-1:0] rise_q, rise_d;
    logic [GPIO_WIDTH-1:0] fall_q, fall_d;
    logic [CNT_WIDTH-1:0]  cnt_q [GPIO_WIDTH];
    logic [CNT_WIDTH-1:0]  cnt_d [GPIO_WIDTH];

    // Pads are driven purely from core inputs, so drive holds through reset.
    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
        assign gpio[i] = gpio_oe[i] ? gpio_output[i] : 1'bz;
    end

    assign raw    = (gpio_oe & gpio_output) | (~gpio_oe & gpio);
    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        level_d = level_q;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (debounce_bypass[i]) begin
                level_d[i] = synced[i];
            end else if (synced[i] != level_q[i]) begin
                // A matching sample anywhere in the run leaves cnt_d at 0: no partial credit.
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clock) begin
        // NOTE: counter and synchronizer arrays are small flop banks, not RAM, so they are reset too.
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage capture its predecessor's old value.
            sync_q[0] <= raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign gpio_input = level_q;
    assign gpio_rise  = rise_q;
    assign gpio_fall  = fall_q;

endmodule

// File: tb/tb_gpio_conditioner.sv
// Bench for gpio_conditioner: directed latency/glitch/bypass/reset scenarios
// plus randomized pad activity checked against a window-based reference model.
module tb_gpio_conditioner;

    localparam int W    = 3;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 16;

    logic         clock   = 1'b0;
    logic         reset   = 1'b0;
    logic [W-1:0] tb_oe   = '0;
    logic [W-1:0] tb_out  = '0;
    logic [W-1:0] tb_byp  = '0;
    logic [W-1:0] pad_val = '0;
    wire  [W-1:0] gpio;
    logic [W-1:0] gpio_input, gpio_rise, gpio_fall;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: delay line of raw samples, and per channel the
    // recent edges on which a differing, non-bypassed sample was presented.
    logic [W-1:0] dl [$];
    bit           win [W][$];
    logic [W-1:0] exp_in   = '0;
    logic [W-1:0] exp_rise = '0;
    logic [W-1:0] exp_fall = '0;

    for (genvar i = 0; i < W; i++) begin : g_bench_pad
        assign gpio[i] = tb_oe[i] ? 1'bz : pad_val[i];
    end

    gpio_conditioner #(
        .GPIO_WIDTH     (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH      (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .gpio           (gpio),
        .gpio_oe        (tb_oe),
        .gpio_output    (tb_out),
        .debounce_bypass(tb_byp),
        .gpio_input     (gpio_input),
        .gpio_rise      (gpio_rise),
        .gpio_fall      (gpio_fall)
    );

    always #5 clock = ~clock;

    // A level is accepted once DEB consecutive edges since the last change all
    // presented the opposite level without bypass; bypass copies straight through.
    task automatic model_edge(input logic [W-1:0] r, input logic [W-1:0] byp, input logic rst_n);
        logic [W-1:0] s;
        logic [W-1:0] nq;
        int           ones;
        if (!rst_n) begin
            dl = {};
            repeat (SYNC) dl.push_back('0);
            for (int ch = 0; ch < W; ch++) win[ch].delete();
            exp_in   = '0;
            exp_rise = '0;
            exp_fall = '0;
            return;
        end
        s = dl.pop_front();
        dl.push_back(r);
        nq = exp_in;
        for (int ch = 0; ch < W; ch++) begin
            win[ch].push_back(!byp[ch] && (s[ch] != exp_in[ch]));
            if (win[ch].size() > DEB) void'(win[ch].pop_front());
            ones = 0;
            for (int k = 0; k < win[ch].size(); k++) ones += int'(win[ch][k]);
            if (byp[ch]) nq[ch] = s[ch];
            else if (ones == DEB) nq[ch] = s[ch];
            if (nq[ch] != exp_in[ch]) win[ch].delete();
        end
        exp_rise = nq & ~exp_in;
        exp_fall = ~nq & exp_in;
        exp_in   = nq;
    endtask

    // One clock edge: capture what the DUT samples, advance the model, land on the falling edge.
    task automatic tick();
        logic [W-1:0] r;
        logic [W-1:0] b;
        logic         rn;
        r  = (tb_oe & tb_out) | (~tb_oe & pad_val);
        b  = tb_byp;
        rn = reset;
        @(posedge clock);
        model_edge(r, b, rn);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        tb_oe[2]  = 1'b1;
        tb_out[2] = 1'b1;
        #1;
        n_cmp++;
        if (gpio[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pad_drive: got %b want 1", gpio[2]);
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            tb_oe  = '0;
            tb_out = '0;
            n_cmp++;
            if ({gpio_input, gpio_rise, gpio_fall} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got in=%b r=%b f=%b want all 0", t, gpio_input, gpio_rise, gpio_fall);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_latency();
        pad_val[0] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_cmp++;
            if (gpio_input[0] !== (t >= 6) || gpio_rise[0] !== (t == 6)) begin
                n_bad++;
                $display("FAIL latency_rise t=%0d: got in=%b rise=%b want in=%b rise=%b", t, gpio_input[0], gpio_rise[0], t >= 6, t == 6);
            end
        end
        pad_val[0] = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_cmp++;
            if (gpio_input[0] !== (t < 6) || gpio_fall[0] !== (t == 6)) begin
                n_bad++;
                $display("FAIL latency_fall t=%0d: got in=%b fall=%b want in=%b fall=%b", t, gpio_input[0], gpio_fall[0], t < 6, t == 6);
            end
        end
    endtask

    task automatic test_glitch();
        int rise_t;
        int fall_t;
        int n_rise;
        int n_fall;
        pad_val[1] = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            if (t == 4) pad_val[1] = 1'b0;
            tick();
            n_cmp++;
            if (gpio_input[1] !== 1'b0 || gpio_rise[1] !== 1'b0 || gpio_fall[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_3cyc t=%0d: got in=%b r=%b f=%b want 0 0 0", t, gpio_input[1], gpio_rise[1], gpio_fall[1]);
            end
        end
        rise_t = 0; fall_t = 0; n_rise = 0; n_fall = 0;
        pad_val[1] = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            if (t == 5) pad_val[1] = 1'b0;
            tick();
            if (gpio_rise[1] === 1'b1) begin rise_t = t; n_rise++; end
            if (gpio_fall[1] === 1'b1) begin fall_t = t; n_fall++; end
        end
        n_cmp++;
        if (rise_t != 6 || fall_t != 10 || n_rise != 1 || n_fall != 1) begin
            n_bad++;
            $display("FAIL glitch_4cyc: got rise@%0d x%0d fall@%0d x%0d want rise@6 x1 fall@10 x1", rise_t, n_rise, fall_t, n_fall);
        end
    endtask

    task automatic test_bypass();
        tb_byp[2]  = 1'b1;
        pad_val[2] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            n_cmp++;
            if (gpio_input[2] !== (t >= 3) || gpio_rise[2] !== (t == 3)) begin
                n_bad++;
                $display("FAIL bypass_rise t=%0d: got in=%b rise=%b want in=%b rise=%b", t, gpio_input[2], gpio_rise[2], t >= 3, t == 3);
            end
        end
        pad_val[2] = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            pad_val[2] = 1'b1;
            n_cmp++;
            if (gpio_input[2] !== (t != 3) || gpio_fall[2] !== (t == 3) || gpio_rise[2] !== (t == 4)) begin
                n_bad++;
                $display("FAIL bypass_glitch t=%0d: got in=%b r=%b f=%b want in=%b r=%b f=%b", t, gpio_input[2], gpio_rise[2], gpio_fall[2], t != 3, t == 4, t == 3);
            end
        end
        tb_byp[2] = 1'b0;
    endtask

    task automatic test_loopback();
        tb_oe[0]  = 1'b1;
        tb_out[0] = 1'b1;
        #1;
        n_cmp++;
        if (gpio[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL loopback_pad: got %b want 1", gpio[0]);
        end
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_cmp++;
            if (gpio_input[0] !== (t >= 6) || gpio_rise[0] !== (t == 6)) begin
                n_bad++;
                $display("FAIL loopback_rise t=%0d: got in=%b rise=%b want in=%b rise=%b", t, gpio_input[0], gpio_rise[0], t >= 6, t == 6);
            end
        end
        tb_oe[0] = 1'b0;
        #1;
        n_cmp++;
        if (gpio[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL loopback_release: got %b want 0", gpio[0]);
        end
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_cmp++;
            if (gpio_input[0] !== (t < 6) || gpio_fall[0] !== (t == 6)) begin
                n_bad++;
                $display("FAIL loopback_fall t=%0d: got in=%b fall=%b want in=%b fall=%b", t, gpio_input[0], gpio_fall[0], t < 6, t == 6);
            end
        end
        tb_out[0] = 1'b0;
    endtask

    task automatic test_reset_midcount();
        pad_val[1] = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (gpio_input[1] !== 1'b0 || gpio_rise[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midcount_pre: got in=%b rise=%b want 0 0", gpio_input[1], gpio_rise[1]);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++;
        if ({gpio_input, gpio_rise, gpio_fall} !== '0) begin
            n_bad++;
            $display("FAIL midcount_reset: got in=%b r=%b f=%b want all 0", gpio_input, gpio_rise, gpio_fall);
        end
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_cmp++;
            if (gpio_input[1] !== (t >= 6) || gpio_rise[1] !== (t == 6) || gpio_fall[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL midcount_release t=%0d: got in=%b r=%b f=%b want in=%b r=%b f=0", t, gpio_input[1], gpio_rise[1], gpio_fall[1], t >= 6, t == 6);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_pad;
        int           flip_odds;
        for (int n = 0; n < 1500; n++) begin
            flip_odds = ((n / 150) % 2 == 0) ? 2 : 7;
            reset = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(flip_odds) == 0) pad_val[i] = ~pad_val[i];
                if ($urandom_range(29) == 0)        tb_oe[i]   = ~tb_oe[i];
                if ($urandom_range(5) == 0)         tb_out[i]  = 1'($urandom_range(1));
                if ($urandom_range(59) == 0)        tb_byp[i]  = ~tb_byp[i];
            end
            #1;
            exp_pad = (tb_oe & tb_out) | (~tb_oe & pad_val);
            n_cmp++;
            if (gpio !== exp_pad) begin
                n_bad++;
                $display("FAIL random_pad n=%0d: got %b want %b", n, gpio, exp_pad);
            end
            tick();
            n_cmp++;
            if ({gpio_input, gpio_rise, gpio_fall} !== {exp_in, exp_rise, exp_fall}) begin
                n_bad++;
                $display("FAIL random_model n=%0d: got in=%b r=%b f=%b want in=%b r=%b f=%b",
                         n, gpio_input, gpio_rise, gpio_fall, exp_in, exp_rise, exp_fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_bypass();
        test_loopback();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_conditioner.md
GPIO_CONDITIONER -- requirements
Module: gpio_conditioner

Interface
REQ-001 The block SHALL have parameter GPIO_WIDTH, default 3, number of independent GPIO channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count per channel (2..4).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 12000, clock edges a new level must persist before acceptance (>=1; 1 ms at 12 MHz).
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, debounce counter width; DEBOUNCE_CYCLES <= 2^CNT_WIDTH required.
REQ-005 The block SHALL have clock  input  1  single system clock, all flops rising-edge.
REQ-006 The block SHALL have reset  input  1  synchronous, active-low reset: reset=0 at a rising clock edge clears all state.
REQ-007 The block SHALL have gpio  inout  GPIO_WIDTH  board pads.
REQ-008 The block SHALL have gpio_oe  input  GPIO_WIDTH  per-channel output enable from core.
REQ-009 The block SHALL have gpio_output  input  GPIO_WIDTH  per-channel drive value from core.
REQ-010 The block SHALL have debounce_bypass  input  GPIO_WIDTH  per-channel debounce skip.
REQ-011 The block SHALL have gpio_input  output  GPIO_WIDTH  conditioned (synchronized, debounced) level to core.
REQ-012 The block SHALL have gpio_rise  output  GPIO_WIDTH  one-cycle pulse on accepted 0->1 of gpio_input.
REQ-013 The block SHALL have gpio_fall  output  GPIO_WIDTH  one-cycle pulse on accepted 1->0 of gpio_input.

Function
REQ-014 Pad drive SHALL be combinational: gpio[i] = gpio_output[i] when gpio_oe[i]=1, else high-Z.
REQ-015 Raw sample r[i] SHALL be gpio_output[i] when gpio_oe[i]=1, else gpio[i] (loopback of driven value).
REQ-016 r[i] SHALL pass through SYNC_STAGES flops; last stage is s[i]; no logic between stages.
REQ-017 Per channel, state SHALL be stable level q[i] (drives gpio_input[i]) and counter c[i] (CNT_WIDTH bits).
REQ-018 Bypass=0, s==q: c <= 0, q held.
REQ-019 Bypass=0, s!=q, c < DEBOUNCE_CYCLES-1: c <= c+1, q held.
REQ-020 Bypass=0, s!=q, c == DEBOUNCE_CYCLES-1: q <= s, c <= 0.
REQ-021 Any cycle with s==q before acceptance SHALL restart the count from 0 (glitch rejection; no partial credit).
REQ-022 Bypass=1: q <= s every cycle, c <= 0; bypass change mid-count takes effect next edge.
REQ-023 Pad-to-gpio_input latency SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES edges for a held change; SYNC_STAGES + 1 when bypassed.
REQ-024 gpio_rise[i]/gpio_fall[i] SHALL be registered, asserted exactly in the first cycle gpio_input[i] shows the new level, deasserted the next cycle.
REQ-025 gpio_rise and gpio_fall SHALL never be high together on one channel; channels SHALL be fully independent.
REQ-026 Toggling gpio_oe mid-count SHALL only change r; counter continues per REQ-018..020 on resulting s.
REQ-027 Counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap); DEBOUNCE_CYCLES=1 behaves as accept-next-edge.

Reset
REQ-028 While reset=0 at an edge: all sync flops, q, c, gpio_input, gpio_rise, gpio_fall SHALL clear to 0.
REQ-029 gpio pad drive SHALL remain combinational during reset (follows gpio_oe/gpio_output).
REQ-030 Reset asserted mid-count SHALL discard the count with no pulse; after release a pad held at 1 SHALL produce gpio_input=1 and one gpio_rise pulse after REQ-023 latency.

Verification (GPIO_WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-031 Reset=0 for 3 edges, pads 0 -> all outputs 0; release, drive gpio[0]=1 before edge E0 -> gpio_input[0]=1 after E5, gpio_rise[0]=1 only the cycle after E5.
REQ-032 gpio[1] pulsed 1 for 3 cycles then 0 -> gpio_input[1] stays 0, no rise/fall pulse; 4-cycle pulse -> accepted, rise then fall pulses 4 cycles apart.
REQ-033 debounce_bypass[2]=1, gpio[2] 0->1 before E0 -> gpio_input[2]=1 after E2 with one rise pulse; 1-cycle glitch passes through.
REQ-034 gpio_oe[0]=1, gpio_output[0]=1 -> pad reads 1 immediately, gpio_input[0]=1 after 6 edges; gpio_oe[0]=0 with bench driving 0 -> fall pulse after 6 edges.
REQ-035 gpio[1] held 1 for 2 counted edges, reset=0 one edge -> outputs 0, no pulse; release with pad still 1 -> gpio_input[1]=1 exactly 6 edges later.
